// File: rtl/ro_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : ro_freq_counter
// Purpose  : Ring-oscillator frequency measurement stage. Enables the RO,
//            waits a fixed settling time, then counts rising edges of the
//            (synchronized) RO output over a programmable gate window of
//            ro_clk cycles. The count is held with a valid/start handshake.
// Ports    :
//   ro_clk        in   measurement clock (rising edge)
//   ro_rst_n      in   asynchronous active-low reset
//   start         in   single-cycle measurement request
//   abort         in   cancel an in-flight measurement
//   gate_len      in   gate window length in ro_clk cycles (latched on start)
//   ro_q_in       in   ring-oscillator output, asynchronous to ro_clk
//   ro_en_out     out  registered RO enable
//   busy          out  high during WARMUP and GATE
//   result_valid  out  result holds a completed measurement
//   result        out  rising-edge count (saturating)
//   overflow      out  count saturated during the last measurement
// Revision : 1.0  initial release
// ============================================================================
module ro_freq_counter #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int WARMUP_CYCLES = 8,   // must be >= SYNC_STAGES+1
    parameter int SYNC_STAGES   = 2
) (
    input  logic              ro_clk,
    input  logic              ro_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              ro_q_in,
    output logic              ro_en_out,
    output logic              busy,
    output logic              result_valid,
    output logic [CNT_W-1:0]  result,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_GATE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int               c_WU_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [c_WU_W-1:0] c_WU_LAST = c_WU_W'(WARMUP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer and edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;
    logic                   w_edge;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_edge = w_sync & ~r_prev;

    // The "previous" flop tracks continuously so it is already settled to
    // the synchronized level when the gate opens; edges before that are
    // simply not counted.
    always_ff @(posedge ro_clk or negedge ro_rst_n) begin
        if (!ro_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= ro_q_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
        end
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state,    w_state;
    logic [c_WU_W-1:0]   r_warm_cnt, w_warm_cnt;
    logic [GATE_W-1:0]   r_gate_cnt, w_gate_cnt;
    logic [GATE_W-1:0]   r_gate_len, w_gate_len;
    logic [CNT_W-1:0]    r_cnt,      w_cnt;
    logic                r_ovf,      w_ovf;
    logic                r_en,       w_en;
    logic                r_busy,     w_busy;
    logic                r_valid,    w_valid;

    always_ff @(posedge ro_clk or negedge ro_rst_n) begin
        if (!ro_rst_n) begin
            r_state    <= S_IDLE;
            r_warm_cnt <= '0;
            r_gate_cnt <= '0;
            r_gate_len <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_warm_cnt <= w_warm_cnt;
            r_gate_cnt <= w_gate_cnt;
            r_gate_len <= w_gate_len;
            r_cnt      <= w_cnt;
            r_ovf      <= w_ovf;
            r_en       <= w_en;
            r_busy     <= w_busy;
            r_valid    <= w_valid;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_warm_cnt = r_warm_cnt;
        w_gate_cnt = r_gate_cnt;
        w_gate_len = r_gate_len;
        w_cnt      = r_cnt;
        w_ovf      = r_ovf;
        w_en       = r_en;
        w_busy     = r_busy;
        w_valid    = r_valid;

        case (r_state)
            S_IDLE, S_DONE: begin
                // abort alongside start drops the start
                if (start && !abort) begin
                    w_state    = S_WARMUP;
                    w_gate_len = gate_len;
                    w_warm_cnt = '0;
                    w_cnt      = '0;
                    w_ovf      = 1'b0;
                    w_valid    = 1'b0;
                    w_en       = 1'b1;
                    w_busy     = 1'b1;
                end
            end

            S_WARMUP: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                    w_valid = 1'b0;
                    w_cnt   = '0;
                    w_ovf   = 1'b0;
                end else if (r_warm_cnt == c_WU_LAST) begin
                    w_gate_cnt = '0;
                    if (r_gate_len != '0) begin
                        w_state = S_GATE;
                    end else begin
                        // empty window: finish with a zero count
                        w_state = S_DONE;
                        w_en    = 1'b0;
                        w_busy  = 1'b0;
                        w_valid = 1'b1;
                    end
                end else begin
                    w_warm_cnt = r_warm_cnt + c_WU_W'(1);
                end
            end

            S_GATE: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                    w_valid = 1'b0;
                    w_cnt   = '0;
                    w_ovf   = 1'b0;
                end else begin
                    if (w_edge) begin
                        if (&r_cnt) begin
                            w_ovf = 1'b1;
                        end else begin
                            w_cnt = r_cnt + CNT_W'(1);
                        end
                    end
                    // r_gate_len is non-zero here, so the subtraction cannot wrap
                    if (r_gate_cnt == (r_gate_len - GATE_W'(1))) begin
                        w_state = S_DONE;
                        w_en    = 1'b0;
                        w_busy  = 1'b0;
                        w_valid = 1'b1;
                    end else begin
                        w_gate_cnt = r_gate_cnt + GATE_W'(1);
                    end
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign ro_en_out    = r_en;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result       = r_cnt;
    assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ro_freq_counter
// Purpose  : Self-checking bench for ro_freq_counter. Two instances share
//            stimulus: one with default widths, one with CNT_W=4 for the
//            saturation cases. Measurements come from a vector table; the
//            expected record is queued when start is driven and popped when
//            result_valid appears.
// Revision : 1.0  initial release
// ============================================================================
module tb_ro_freq_counter;

    localparam int W = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ro_q  = 1'b0;
    logic [15:0] gate_len = '0;

    logic        a_en, a_busy, a_valid, a_ovf;
    logic [15:0] a_res;
    logic        b_en, b_busy, b_valid, b_ovf;
    logic [3:0]  b_res;

    ro_freq_counter #(.CNT_W(16), .GATE_W(16), .WARMUP_CYCLES(W), .SYNC_STAGES(2)) dut_a (
        .ro_clk(clk), .ro_rst_n(rst_n), .start(start), .abort(abort),
        .gate_len(gate_len), .ro_q_in(ro_q), .ro_en_out(a_en), .busy(a_busy),
        .result_valid(a_valid), .result(a_res), .overflow(a_ovf)
    );

    ro_freq_counter #(.CNT_W(4), .GATE_W(16), .WARMUP_CYCLES(W), .SYNC_STAGES(2)) dut_b (
        .ro_clk(clk), .ro_rst_n(rst_n), .start(start), .abort(abort),
        .gate_len(gate_len), .ro_q_in(ro_q), .ro_en_out(b_en), .busy(b_busy),
        .result_valid(b_valid), .result(b_res), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    // RO model: square wave with ro_period clk cycles, 0 = stuck low
    int ro_period = 0;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (ro_period == 0) begin
                ro_q = 1'b0;
                ph   = 0;
            end else begin
                ro_q = (ph < ro_period / 2);
                ph   = (ph + 1) % ro_period;
            end
        end
    end

    typedef struct {
        int gate;
        int period;
        int use_b;
        int exp_res;
        int tol;
        int exp_ovf;
        int poke_k;    // cycle at which a busy-time start is injected (0 = none)
        int poke_len;  // gate_len driven with that injected start
    } vec_t;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    endtask

    function automatic logic [31:0] outs_a();
        return {8'd0, a_en, a_busy, a_valid, a_ovf, 4'd0, a_res};
    endfunction

    function automatic logic [31:0] outs_b();
        return {24'd0, b_en, b_busy, b_valid, b_ovf, b_res};
    endfunction

    // Called at a negedge; drives start and follows the measurement to result_valid
    task automatic measure(input vec_t v);
        int    busy_n, en_bad, lat, res, ovf, en_v, busy_v;
        bit    got;
        vec_t  e;
        logic  s_en, s_busy, s_valid;
        ro_period = v.period;
        gate_len  = 16'(v.gate);
        start     = 1'b1;
        exp_q.push_back(v);
        busy_n = 0; en_bad = 0; lat = 0; got = 0;
        res = 0; ovf = 0; en_v = 0; busy_v = 0;
        for (int k = 1; k <= W + v.gate + 40 && !got; k++) begin
            @(negedge clk);
            s_en    = v.use_b != 0 ? b_en    : a_en;
            s_busy  = v.use_b != 0 ? b_busy  : a_busy;
            s_valid = v.use_b != 0 ? b_valid : a_valid;
            if (s_valid) begin
                got    = 1;
                lat    = k;
                res    = v.use_b != 0 ? int'(b_res) : int'(a_res);
                ovf    = v.use_b != 0 ? int'(b_ovf) : int'(a_ovf);
                en_v   = int'(s_en);
                busy_v = int'(s_busy);
            end else begin
                if (s_busy) busy_n++;
                if (s_en !== s_busy) en_bad++;
                start = (k == v.poke_k);
                if (k == v.poke_k) gate_len = 16'(v.poke_len);
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        chk("valid_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(1 + W + e.gate));
        chk("busy_cycles", 32'(busy_n), 32'(W + e.gate));
        chk("en_tracks_busy", 32'(en_bad), 32'd0);
        chk("en_low_at_valid", 32'(en_v), 32'd0);
        chk("busy_low_at_valid", 32'(busy_v), 32'd0);
        chk_rng("result", res, e.exp_res - e.tol, e.exp_res + e.tol);
        chk("overflow", 32'(ovf), 32'(e.exp_ovf));
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            gate period b  exp tol ovf poke len
        vecs[0] = '{  64,   8,   0,   8,  1,  0,  0,   0};  // nominal
        vecs[1] = '{  32,   0,   0,   0,  0,  0,  0,   0};  // stuck RO
        vecs[2] = '{   0,   8,   0,   0,  0,  0,  0,   0};  // zero gate
        vecs[3] = '{  60,   6,   0,  10,  1,  0,  0,   0};
        vecs[4] = '{ 160,   4,   1,  15,  0,  1,  0,   0};  // saturation, CNT_W=4
        vecs[5] = '{  16,   4,   1,   4,  1,  0,  0,   0};  // overflow cleared
        vecs[6] = '{  24,   8,   0,   3,  1,  0,  3, 200};  // start while busy
        vecs[7] = '{   1,   0,   0,   0,  0,  0,  0,   0};  // single-cycle gate

        // Reset held with RO toggling
        ro_period = 4;
        repeat (4) @(negedge clk);
        chk("reset_outs_a", outs_a(), 32'd0);
        chk("reset_outs_b", outs_b(), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_outs_a", outs_a(), 32'd0);
        chk("idle_outs_b", outs_b(), 32'd0);

        // Table-driven measurements, back to back
        for (int i = 0; i < 8; i++) begin
            measure(vecs[i]);
        end

        // Abort 10 cycles into GATE
        ro_period = 8;
        gate_len  = 16'd64;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 9) @(negedge clk);
        chk("busy_before_abort", 32'(a_busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outs_a", outs_a(), 32'd0);
        chk("abort_outs_b", outs_b(), 32'd0);

        // start and abort together: start dropped
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("collide_outs_a", outs_a(), 32'd0);
        @(negedge clk);
        chk("collide_still_idle", outs_a(), 32'd0);

        // Asynchronous reset pulse mid-GATE
        gate_len = 16'd64;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("busy_before_reset", 32'(a_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs_a", outs_a(), 32'd0);
        chk("async_reset_outs_b", outs_b(), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        measure(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ro_freq_counter.md
# ro_freq_counter

Measurement stage directly downstream of the ring oscillator. It enables the oscillator, waits a fixed settling time and then counts rising edges of the asynchronous `ro_q` over a programmable gate window of `ro_clk` cycles. It presents the count as a held result with a valid/start handshake. The oscillator output reaches this block divided, or at least below `ro_clk`/2, so synchronous sampling captures every period.

## Interface
- `CNT_W`, default 16: result counter width.
- `GATE_W`, default 16: gate-length width.
- `WARMUP_CYCLES`, default 8: settling cycles between RO enable and gate open; must be ≥ `SYNC_STAGES`+1.
- `SYNC_STAGES`, default 2: synchronizer flops on `ro_q_in`.

Ports:
- `ro_clk`  in  1  measurement clock; all logic is rising-edge.
- `ro_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request for a measurement.
- `abort`  in  1  cancels an in-flight measurement.
- `gate_len`  in  GATE_W  gate window in `ro_clk` cycles; latched when `start` is accepted.
- `ro_q_in`  in  1  ring-oscillator output, asynchronous to `ro_clk`.
- `ro_en_out`  out  1  registered enable to the ring oscillator.
- `busy`  out  1  high in WARMUP and GATE.
- `result_valid`  out  1  `result` holds a completed measurement.
- `result`  out  CNT_W  rising-edge count.
- `overflow`  out  1  count saturated during the last measurement.

## Operation
- FSM states: IDLE, WARMUP, GATE, DONE. All outputs are registered.
- Reset (async assert, sync deassert at first edge):
  - state = IDLE; all outputs are 0 (`result` = 0, `ro_en_out` = 0).
  - Sync chain, edge-detect flop, warmup counter and gate counter are 0.
- IDLE or DONE with `start`=1 and `abort`=0:
  - Latch `gate_len`, clear the counter and `overflow`, drop `result_valid`.
  - Go to WARMUP with `ro_en_out`=1.
- WARMUP: count `WARMUP_CYCLES` cycles. The edge-detect "previous" flop tracks the synchronized signal but no edges are counted. Then:
  - latched `gate_len` ≠ 0 → GATE;
  - latched `gate_len` = 0 → DONE with `result` = 0.
- GATE: lasts exactly the latched `gate_len` cycles. Each cycle with synchronized `ro_q`=1 and previous=0 increments the count.
  - The count saturates at 2^CNT_W−1; a further edge at saturation sets `overflow`.
  - After the last gate cycle → DONE.
- DONE:
  - `ro_en_out`=0 and `result_valid`=1.
  - `result` and `overflow` hold until the next accepted `start`.
- `abort` in WARMUP or GATE:
  - Next state IDLE; `ro_en_out`=0.
  - `result_valid`=0, `result`=0, `overflow`=0.
- `abort` in IDLE or DONE: ignored.
- `start` and `abort` in the same cycle: `abort` wins and `start` is dropped.
- `start` while `busy`: ignored; the latched `gate_len` is unchanged.
- `gate_len` changes after acceptance have no effect on the running measurement.

## Timing
- Start accepted at edge N:
  - `busy`=1 and `ro_en_out`=1 from N+1;
  - the gate covers cycles N+1+`WARMUP_CYCLES` through N+`WARMUP_CYCLES`+latched `gate_len`;
  - `result_valid`=1 one cycle after the last gate cycle.
- Total latency from `start` to `result_valid` = 1 + `WARMUP_CYCLES` + `gate_len` cycles. For `gate_len`=0 it is 1 + `WARMUP_CYCLES`.
- Edge latency: a rising edge on `ro_q_in` is counted `SYNC_STAGES`+1 cycles after it is sampled. Edges within `SYNC_STAGES`+1 cycles of either gate boundary may fall on either side, so accuracy is ±1 count.
- `ro_en_out` falls on the same edge that `result_valid` rises. On abort, it falls on the edge after `abort` is sampled.
- Back-to-back operation: `start` in the first DONE cycle is accepted; `result_valid` drops on the next edge.
- Reset asserted mid-measurement: immediate return to reset values. No partial result is kept.

## Test plan
- Reset:
  - Stimulus: hold `ro_rst_n`=0 with `ro_q_in` toggling.
  - Required: all outputs 0. Release, idle 5 cycles: still 0, `ro_en_out`=0.
- Nominal measurement:
  - Stimulus: `ro_q_in` square wave with period 8 `ro_clk`; `start` with `gate_len`=64.
  - Required: `busy` for 72 cycles; `result_valid`=1 at cycle 73; `result` = 8±1; `overflow`=0; `ro_en_out` high exactly during `busy`.
- Stuck oscillator and zero gate:
  - Stimulus: `ro_q_in`=0, `gate_len`=32.
  - Required: `result`=0, valid after 41 cycles.
  - Stimulus: `gate_len`=0.
  - Required: `result`=0, valid after 9 cycles.
- Saturation:
  - Stimulus: `CNT_W`=4, `ro_q_in` period 4, `gate_len`=160.
  - Required: `result`=15, `overflow`=1.
  - Stimulus: next measurement with `gate_len`=16.
  - Required: `overflow` cleared, `result`=4±1.
- Abort and collisions:
  - Stimulus: `abort` 10 cycles into GATE.
  - Required: next cycle IDLE; `ro_en_out`=0, `result_valid`=0, `result`=0.
  - Stimulus: `start` with `abort` in the same cycle.
  - Required: stays IDLE.
  - Stimulus: `start` with a new `gate_len` during `busy`.
  - Required: ignored; the original window length is used.
- Async reset mid-GATE:
  - Stimulus: pulse `ro_rst_n` low between clock edges.
  - Required: outputs zero immediately. A following `start` with `gate_len`=64 reproduces the nominal result.
